// File: rtl/adc_capture_channel.sv
// ADC capture channel: optional level trigger, decimation, 4:1 byte packing, FWFT word FIFO to USB.
// Define ADC_CAPTURE_TRIGGER_EN to build the WAIT_TRIG state and the level-crossing trigger.
module adc_capture_channel #(
  parameter int DEPTH       = 1024,
  parameter int DECIM_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             adc_data,
  input  logic                   adc_valid,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DECIM_WIDTH-1:0] decim,
  input  logic [31:0]            length,
  input  logic [7:0]             trig_level,
  input  logic                   trig_slope,
  output logic [31:0]            usb_wr_data,
  output logic                   usb_wr_data_valid,
  input  logic                   usb_wr_full,
  output logic                   busy,
  output logic                   overflow,
  output logic [31:0]            words_sent
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            mem [DEPTH];
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [23:0]            pack_q, pack_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [31:0]            word_cnt_q, word_cnt_d;
  logic [31:0]            len_q, len_d;
  logic [DECIM_WIDTH-1:0] dec_cnt_q, dec_cnt_d, dec_lim_q, dec_lim_d;
  logic                   overflow_q, overflow_d;
  logic [31:0]            words_sent_q, words_sent_d;
  logic [31:0]            hold_q, hold_d;

`ifdef ADC_CAPTURE_TRIGGER_EN
  logic [7:0] prev_q, prev_d;
  logic       prev_valid_q, prev_valid_d;
  logic       rise_hit, fall_hit;
`else
  logic       unused_trig;
  assign unused_trig = ^{trig_level, trig_slope};
`endif

  logic [AW:0] fifo_count;
  logic        fifo_empty, fifo_full, pop, push_req, push_ok;
  logic        trig_hit, advance, accept;
  logic [31:0] push_word, head_word;

  assign fifo_count        = wr_ptr_q - rd_ptr_q;
  assign fifo_empty        = (fifo_count == '0);
  assign fifo_full         = fifo_count[AW];
  assign pop               = !fifo_empty && !usb_wr_full;
  assign head_word         = mem[rd_ptr_q[AW-1:0]];
  assign usb_wr_data_valid = pop;
  // Output only changes on a transfer so the USB side never sees a moving word.
  assign usb_wr_data       = pop ? head_word : hold_q;
  assign busy              = (state_q != IDLE);
  assign overflow          = overflow_q;
  assign words_sent        = words_sent_q;

`ifdef ADC_CAPTURE_TRIGGER_EN
  assign rise_hit = ($signed(prev_q) < $signed(trig_level)) && ($signed(adc_data) >= $signed(trig_level));
  assign fall_hit = ($signed(prev_q) > $signed(trig_level)) && ($signed(adc_data) <= $signed(trig_level));
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q + (AW+1)'(pop);
    pack_d       = pack_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    dec_cnt_d    = dec_cnt_q;
    dec_lim_d    = dec_lim_q;
    overflow_d   = overflow_q;
    words_sent_d = words_sent_q + 32'(pop);
    hold_d       = usb_wr_data;
    push_req     = 1'b0;
    push_ok      = 1'b0;
    push_word    = {adc_data, pack_q};
    trig_hit     = 1'b0;
`ifdef ADC_CAPTURE_TRIGGER_EN
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    if (state_q == WAIT_TRIG && adc_valid) begin
      prev_d       = adc_data;
      prev_valid_d = 1'b1;
      trig_hit     = prev_valid_q && (trig_slope ? fall_hit : rise_hit);
    end
`endif

    // The triggering sample counts as the first decimation slot of the capture.
    advance = adc_valid && ((state_q == CAPTURE) || trig_hit);
    accept  = advance && (dec_cnt_q == '0);

    if (advance) begin
      if (dec_cnt_q == dec_lim_q) begin
        dec_cnt_d = '0;
        dec_lim_d = decim;
      end else begin
        dec_cnt_d = dec_cnt_q + 1'b1;
      end
    end

    if (trig_hit) state_d = CAPTURE;

    if (accept) begin
      if (byte_cnt_q == 2'd3) begin
        push_req   = 1'b1;
        byte_cnt_d = 2'd0;
        word_cnt_d = word_cnt_q + 32'd1;
        if (len_q != '0 && word_cnt_d == len_q) state_d = DRAIN;
      end else begin
        pack_d[8*byte_cnt_q +: 8] = adc_data;
        byte_cnt_d                = byte_cnt_q + 2'd1;
      end
    end

    push_ok  = push_req && (!fifo_full || pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    if (push_req && !push_ok) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          overflow_d   = 1'b0;
          words_sent_d = '0;
          pack_d       = '0;
          byte_cnt_d   = '0;
          word_cnt_d   = '0;
          dec_cnt_d    = '0;
          dec_lim_d    = decim;
          len_d        = length;
`ifdef ADC_CAPTURE_TRIGGER_EN
          prev_valid_d = 1'b0;
          state_d      = WAIT_TRIG;
`else
          state_d      = CAPTURE;
`endif
        end
      end
      DRAIN: if (fifo_empty) state_d = IDLE;
      default: ;
    endcase

    // Abort flushes everything in flight but keeps the status counters for inspection.
    if (abort) begin
      state_d    = IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pack_d     = '0;
      byte_cnt_d = '0;
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pack_q       <= '0;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      dec_cnt_q    <= '0;
      dec_lim_q    <= '0;
      overflow_q   <= 1'b0;
      words_sent_q <= '0;
      hold_q       <= '0;
`ifdef ADC_CAPTURE_TRIGGER_EN
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pack_q       <= pack_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      dec_cnt_q    <= dec_cnt_d;
      dec_lim_q    <= dec_lim_d;
      overflow_q   <= overflow_d;
      words_sent_q <= words_sent_d;
      hold_q       <= hold_d;
`ifdef ADC_CAPTURE_TRIGGER_EN
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_adc_capture_channel.sv
// Directed self-checking bench for adc_capture_channel built with a 4-word FIFO.
module tb_adc_capture_channel;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic        start;
  logic        abort;
  logic [15:0] decim;
  logic [31:0] length;
  logic [7:0]  trig_level;
  logic        trig_slope;
  logic [31:0] usb_wr_data;
  logic        usb_wr_data_valid;
  logic        usb_wr_full;
  logic        busy;
  logic        overflow;
  logic [31:0] words_sent;

  int tests_run    = 0;
  int tests_failed = 0;

  adc_capture_channel #(.DEPTH(4), .DECIM_WIDTH(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .adc_data          (adc_data),
    .adc_valid         (adc_valid),
    .start             (start),
    .abort             (abort),
    .decim             (decim),
    .length            (length),
    .trig_level        (trig_level),
    .trig_slope        (trig_slope),
    .usb_wr_data       (usb_wr_data),
    .usb_wr_data_valid (usb_wr_data_valid),
    .usb_wr_full       (usb_wr_full),
    .busy              (busy),
    .overflow          (overflow),
    .words_sent        (words_sent)
  );

  always #5 clk = ~clk;

  // Drive one cycle of ADC input, then advance just past the next rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic pulseStart(input logic [15:0] dec, input logic [31:0] len);
    decim  = dec;
    length = len;
    start  = 1'b1;
    applyStimulus(1'b0, 8'h00);
    start  = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 50) begin
      applyStimulus(1'b0, 8'h00);
      n++;
    end
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    adc_data    = 8'h00;
    adc_valid   = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    decim       = 16'd0;
    length      = 32'd0;
    trig_level  = 8'h00;
    trig_slope  = 1'b0;
    usb_wr_full = 1'b0;
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00);

    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_valid", {31'd0, usb_wr_data_valid}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("reset_words_sent", words_sent, 32'd0);
    checkOutput("reset_data", usb_wr_data, 32'd0);

`ifdef ADC_CAPTURE_TRIGGER_EN
    trig_level = 8'h10;
    trig_slope = 1'b0;
    pulseStart(16'd0, 32'd1);
    applyStimulus(1'b1, 8'h05);
    checkOutput("trig_hold_05", {30'd0, busy, usb_wr_data_valid}, 32'd2);
    applyStimulus(1'b1, 8'h0F);
    checkOutput("trig_hold_0f", {30'd0, busy, usb_wr_data_valid}, 32'd2);
    applyStimulus(1'b1, 8'h10);
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h12);
    applyStimulus(1'b1, 8'h20);
    checkOutput("trig_valid", {31'd0, usb_wr_data_valid}, 32'd1);
    checkOutput("trig_word", usb_wr_data, 32'h2012_1110);
    waitIdle("trig_idle");
`endif

    // Basic capture: two words from a ramp.
    pulseStart(16'd0, 32'd2);
    checkOutput("basic_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(i));
      if (i == 3) begin
        checkOutput("basic_valid0", {31'd0, usb_wr_data_valid}, 32'd1);
        checkOutput("basic_word0", usb_wr_data, 32'h0302_0100);
      end
      if (i == 7) begin
        checkOutput("basic_valid1", {31'd0, usb_wr_data_valid}, 32'd1);
        checkOutput("basic_word1", usb_wr_data, 32'h0706_0504);
      end
    end
    waitIdle("basic_idle");
    checkOutput("basic_words_sent", words_sent, 32'd2);

    // Decimation by 3.
    pulseStart(16'd2, 32'd1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 8'(i));
      if (i == 9) begin
        checkOutput("decim_valid", {31'd0, usb_wr_data_valid}, 32'd1);
        checkOutput("decim_word", usb_wr_data, 32'h0906_0300);
      end
    end
    waitIdle("decim_idle");
    checkOutput("decim_words_sent", words_sent, 32'd1);

    // Backpressure: 6 words into a 4-deep FIFO while the writer is full.
    usb_wr_full = 1'b1;
    pulseStart(16'd0, 32'd6);
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, 8'(i));
    applyStimulus(1'b0, 8'h00);
    checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_busy", {31'd0, busy}, 32'd1);
    checkOutput("ovf_none_sent", words_sent, 32'd0);
    usb_wr_full = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("ovf_drain_valid", {31'd0, usb_wr_data_valid}, 32'd1);
      checkOutput("ovf_drain_word", usb_wr_data,
                  {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
      applyStimulus(1'b0, 8'h00);
    end
    checkOutput("ovf_drain_end", {31'd0, usb_wr_data_valid}, 32'd0);
    waitIdle("ovf_idle");
    checkOutput("ovf_words_sent", words_sent, 32'd4);
    checkOutput("ovf_flag_sticky", {31'd0, overflow}, 32'd1);

    // Abort mid-word with three words queued.
    pulseStart(16'd0, 32'd0);
    checkOutput("abort_ovf_cleared", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(i));
    applyStimulus(1'b0, 8'h00);
    checkOutput("abort_pre_sent", words_sent, 32'd1);
    usb_wr_full = 1'b1;
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 8'(8'h10 + i));
    abort = 1'b1;
    applyStimulus(1'b0, 8'h00);
    abort = 1'b0;
    usb_wr_full = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_valid", {31'd0, usb_wr_data_valid}, 32'd0);
    checkOutput("abort_words_sent", words_sent, 32'd1);
    checkOutput("abort_overflow", {31'd0, overflow}, 32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("abort_fifo_empty", {31'd0, usb_wr_data_valid}, 32'd0);

    // start and abort together from IDLE.
    start = 1'b1;
    abort = 1'b1;
    applyStimulus(1'b0, 8'h00);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_idle", {31'd0, busy}, 32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("start_abort_idle2", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
